// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit common-anode 7-segment scan driver.
package seg_pkg;

  typedef enum logic {
    DEAD = 1'b0,
    ON   = 1'b1
  } slot_state_t;

  // Active-low {dp,g,f,e,d,c,b,a} with dp off.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/seg_scan_driver_decode.sv
// Hex digit to active-low {g..a} segment pattern (combinational).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = SEG_BLANK;
    case (value)
      4'h0: code = SEG_0;
      4'h1: code = SEG_1;
      4'h2: code = SEG_2;
      4'h3: code = SEG_3;
      4'h4: code = SEG_4;
      4'h5: code = SEG_5;
      4'h6: code = SEG_6;
      4'h7: code = SEG_7;
      4'h8: code = SEG_8;
      4'h9: code = SEG_9;
      4'hA: code = SEG_A;
      4'hB: code = SEG_B;
      4'hC: code = SEG_C;
      4'hD: code = SEG_D;
      4'hE: code = SEG_E;
      4'hF: code = SEG_F;
      default: code = SEG_BLANK;
    endcase
    seg = code[6:0];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with frame-synchronous display update.
// Optional leading-zero blanking: define SEG_LZ_BLANK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] n0,
  input  logic [3:0] n1,
  input  logic [3:0] n2,
  input  logic [3:0] n3,
  input  logic [3:0] points,
  input  logic       load,
  output logic [3:0] AN,
  output logic [7:0] SEGMENT
);

  localparam int unsigned   CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);
  localparam slot_state_t   RST_STATE = (DEAD_CYCLES == 0) ? ON : DEAD;

  slot_state_t   state, state_next;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   stage_digits, disp_digits;
  logic [3:0]    stage_points, disp_points;
  logic          pending;
  logic          slot_end, frame_end;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;
  logic [3:0]    an_next;
  logic [7:0]    seg_next;

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    slot_end   = (cnt == CNT_LAST);
    frame_end  = (state == ON) && slot_end && (idx == 2'd3);
    unique case (state)
      DEAD: if (cnt == DEAD_LAST) state_next = ON;
      ON:   if (slot_end && (DEAD_CYCLES != 0)) state_next = DEAD;
    endcase
  end

  assign digit = disp_digits[{idx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .value(digit),
    .seg  (dec_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  logic [3:0] blank;
  always_comb begin
    blank[3] = (disp_digits[15:12] == 4'h0);
    blank[2] = blank[3] && (disp_digits[11:8] == 4'h0);
    blank[1] = blank[2] && (disp_digits[7:4] == 4'h0);
    blank[0] = 1'b0;
  end
`endif

  // Outputs are registered one cycle behind the FSM, so dead time and slot
  // boundaries appear on the pins one edge after the state that produced them.
  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    if (state == ON) begin
      an_next  = ~(4'b0001 << idx);
      seg_next = {~disp_points[idx], dec_seg};
`ifdef SEG_LZ_BLANK_EN
      if (blank[idx]) seg_next[6:0] = SEG_BLANK[6:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      stage_digits <= '0;
      stage_points <= '0;
      disp_digits  <= '0;
      disp_points  <= '0;
      pending      <= 1'b0;
      AN           <= AN_OFF;
      SEGMENT      <= SEG_BLANK;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if ((state == ON) && slot_end) idx <= idx + 2'd1;
      if (frame_end && pending) begin
        disp_digits <= stage_digits;
        disp_points <= stage_points;
        pending     <= 1'b0;
      end
      // A load on the boundary cycle re-arms pending after the transfer above.
      if (load) begin
        stage_digits <= {n3, n2, n1, n0};
        stage_points <= points;
        pending      <= 1'b1;
      end
      AN      <= an_next;
      SEGMENT <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (SCAN_DIV=8, DEAD_CYCLES=2).
module tb_seg_scan_driver;

  localparam int unsigned SCAN_DIV    = 8;
  localparam int unsigned DEAD_CYCLES = 2;
  localparam int unsigned FRAME       = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] n0, n1, n2, n3, points;
  logic       load;
  logic [3:0] AN;
  logic [7:0] SEGMENT;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned k = 0;   // edges since reset release

  logic [7:0] code [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_driver #(
    .SCAN_DIV   (SCAN_DIV),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .n0     (n0),
    .n1     (n1),
    .n2     (n2),
    .n3     (n3),
    .points (points),
    .load   (load),
    .AN     (AN),
    .SEGMENT(SEGMENT)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] p);
    {n3, n2, n1, n0} = d;
    points = p;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Pins after edge kk show the slot position of FSM cycle kk-1.
  function automatic logic [3:0] model_an(int unsigned kk);
    int unsigned c = (kk - 1) % FRAME;
    if ((c % SCAN_DIV) < DEAD_CYCLES) return 4'b1111;
    return ~(4'b0001 << (c / SCAN_DIV));
  endfunction

  function automatic logic [7:0] model_seg(int unsigned kk, logic [15:0] d, logic [3:0] p);
    int unsigned c = (kk - 1) % FRAME;
    int unsigned slot = c / SCAN_DIV;
    logic [7:0] s;
`ifdef SEG_LZ_BLANK_EN
    logic lead_zero = 1'b1;
`endif
    if ((c % SCAN_DIV) < DEAD_CYCLES) return 8'hFF;
    s = code[d[slot*4 +: 4]];
    s[7] = ~p[slot];
`ifdef SEG_LZ_BLANK_EN
    for (int unsigned j = slot; j < 4; j++)
      if (d[j*4 +: 4] != 4'h0) lead_zero = 1'b0;
    if ((slot != 0) && lead_zero) s[6:0] = 7'h7F;
`endif
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {n3, n2, n1, n0} = 16'($urandom);
      points = 4'($urandom);
      load = 1'($urandom);
      step();
      tests++;
      if (AN !== 4'b1111 || SEGMENT !== 8'hFF) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d AN=%b SEGMENT=%h want AN=1111 SEGMENT=ff", i, AN, SEGMENT);
      end
    end
    rst = 1'b0;
    load = 1'b0;
    k = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++;
      if (AN !== ((i == 3) ? 4'b1110 : 4'b1111)) begin
        fails++;
        $display("FAIL first_lit k=%0d AN=%b want %b", k, AN, (i == 3) ? 4'b1110 : 4'b1111);
      end
    end
    tests++;
    if (SEGMENT !== 8'hC0) begin
      fails++;
      $display("FAIL first_lit_seg SEGMENT=%h want c0", SEGMENT);
    end
  endtask

  task automatic test_scan_order();
    drive_load(16'h4321, 4'b0000);
    while (k % FRAME != 0) step();
    for (int i = 0; i < FRAME; i++) begin
      step();
      tests++;
      if (AN !== model_an(k) || SEGMENT !== model_seg(k, 16'h4321, 4'b0000)) begin
        fails++;
        $display("FAIL scan_order k=%0d AN=%b SEGMENT=%h want AN=%b SEGMENT=%h",
                 k, AN, SEGMENT, model_an(k), model_seg(k, 16'h4321, 4'b0000));
      end
    end
  endtask

  task automatic test_tear_free();
    logic [15:0] d;
    int unsigned frame_end = k + FRAME;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (k == frame_end - FRAME + 11) begin
        {n3, n2, n1, n0} = 16'h8888;
        points = 4'b0000;
        load = 1'b1;
      end
      step();
      load = 1'b0;
      d = (k <= frame_end) ? 16'h4321 : 16'h8888;
      tests++;
      if (AN !== model_an(k) || SEGMENT !== model_seg(k, d, 4'b0000)) begin
        fails++;
        $display("FAIL tear_free k=%0d AN=%b SEGMENT=%h want AN=%b SEGMENT=%h",
                 k, AN, SEGMENT, model_an(k), model_seg(k, d, 4'b0000));
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [15:0] d;
    logic [3:0]  p;
    int unsigned f0 = k;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (k == f0 + 12) begin
        {n3, n2, n1, n0} = 16'h1259;
        points = 4'b0100;
        load = 1'b1;
      end
      if (k == f0 + FRAME - 1) begin
        {n3, n2, n1, n0} = 16'hABCD;
        points = 4'b1010;
        load = 1'b1;
      end
      step();
      load = 1'b0;
      if (k <= f0 + FRAME) begin
        d = 16'h8888; p = 4'b0000;
      end else if (k <= f0 + 2 * FRAME) begin
        d = 16'h1259; p = 4'b0100;
      end else begin
        d = 16'hABCD; p = 4'b1010;
      end
      tests++;
      if (AN !== model_an(k) || SEGMENT !== model_seg(k, d, p)) begin
        fails++;
        $display("FAIL boundary_load k=%0d AN=%b SEGMENT=%h want AN=%b SEGMENT=%h",
                 k, AN, SEGMENT, model_an(k), model_seg(k, d, p));
      end
    end
  endtask

  task automatic test_decode_sweep();
    logic [15:0] d;
    for (int g = 0; g < 4; g++) begin
      d = {4'(4*g + 3), 4'(4*g + 2), 4'(4*g + 1), 4'(4*g)};
      drive_load(d, 4'b0001);
      while (k % FRAME != 0) step();
      for (int i = 0; i < FRAME; i++) begin
        step();
        tests++;
        if (AN !== model_an(k) || SEGMENT !== model_seg(k, d, 4'b0001)) begin
          fails++;
          $display("FAIL decode_sweep k=%0d digits=%h AN=%b SEGMENT=%h want AN=%b SEGMENT=%h",
                   k, d, AN, SEGMENT, model_an(k), model_seg(k, d, 4'b0001));
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] pats [2] = '{16'h0005, 16'h0700};
    for (int g = 0; g < 2; g++) begin
      drive_load(pats[g], 4'b0000);
      while (k % FRAME != 0) step();
      for (int i = 0; i < FRAME; i++) begin
        step();
        tests++;
        if (AN !== model_an(k) || SEGMENT !== model_seg(k, pats[g], 4'b0000)) begin
          fails++;
          $display("FAIL lz_blank k=%0d digits=%h AN=%b SEGMENT=%h want AN=%b SEGMENT=%h",
                   k, pats[g], AN, SEGMENT, model_an(k), model_seg(k, pats[g], 4'b0000));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step();
    drive_load(16'h9876, 4'b1111);
    rst = 1'b1;
    step();
    tests++;
    if (AN !== 4'b1111 || SEGMENT !== 8'hFF) begin
      fails++;
      $display("FAIL reset_mid AN=%b SEGMENT=%h want AN=1111 SEGMENT=ff", AN, SEGMENT);
    end
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      tests++;
      if (AN !== model_an(k) || SEGMENT !== model_seg(k, 16'h0000, 4'b0000)) begin
        fails++;
        $display("FAIL reset_discard k=%0d AN=%b SEGMENT=%h want AN=%b SEGMENT=%h",
                 k, AN, SEGMENT, model_an(k), model_seg(k, 16'h0000, 4'b0000));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    {n3, n2, n1, n0} = '0;
    points = '0;
    test_reset();
    test_scan_order();
    test_tear_free();
    test_boundary_load();
    test_decode_sweep();
    test_lz_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
